// File: rtl/tt_ctrl_seq.sv
// Select-interface sequencer for the mux controller: disables the active design, walks the
// controller's ripple counter (reset and/or inc pulses) to a target address, then re-enables.
module tt_ctrl_seq #(
  parameter int ADDR_W     = 10,
  parameter int PULSE_W    = 2,
  parameter int RST_W      = 2,
  parameter int SETTLE     = 4,
  parameter int ALLOW_INCR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic [2:0]        state_dbg
);

  localparam int TMAX = (PULSE_W > RST_W) ? ((PULSE_W > SETTLE) ? PULSE_W : SETTLE)
                                          : ((RST_W > SETTLE) ? RST_W : SETTLE);
  localparam int CW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [CW-1:0] RST_LD    = CW'(RST_W - 1);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DISABLE = 3'd1,
    S_RESET   = 3'd2,
    S_RECOVER = 3'd3,
    S_INC_HI  = 3'd4,
    S_INC_LO  = 3'd5,
    S_SETTLE  = 3'd6
  } state_t;

  state_t            state;
  logic [CW-1:0]     tcnt;
  logic [ADDR_W-1:0] pulses;
  logic              full_mode;
  logic              ena_q;
  logic              shadow_ok;
  logic              incr_ok;

  // The shadow is trusted for the incremental path only once a full reset sequence has
  // been driven to the controller, so the first request after rst always resets.
  assign incr_ok   = (ALLOW_INCR != 0) && shadow_ok && (req_addr >= cur_addr);
  assign busy      = ~req_ready;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      tcnt           <= '0;
      pulses         <= '0;
      full_mode      <= 1'b0;
      ena_q          <= 1'b0;
      shadow_ok      <= 1'b0;
      req_ready      <= 1'b0;
      done           <= 1'b0;
      cur_addr       <= '0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          ctrl_sel_rst_n <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            ctrl_ena  <= 1'b0;
            ena_q     <= req_ena;
            tcnt      <= SETTLE_LD;
            state     <= S_DISABLE;
            if (incr_ok) begin
              full_mode <= 1'b0;
              pulses    <= req_addr - cur_addr;
            end else begin
              full_mode <= 1'b1;
              pulses    <= req_addr;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_DISABLE: begin
          if (tcnt != '0) begin
            tcnt <= tcnt - 1'b1;
          end else if (full_mode) begin
            state          <= S_RESET;
            ctrl_sel_rst_n <= 1'b0;
            cur_addr       <= '0;
            shadow_ok      <= 1'b1;
            tcnt           <= RST_LD;
          end else if (pulses != '0) begin
            state        <= S_INC_HI;
            ctrl_sel_inc <= 1'b1;
            cur_addr     <= cur_addr + 1'b1;
            pulses       <= pulses - 1'b1;
            tcnt         <= PULSE_LD;
          end else begin
            state <= S_SETTLE;
            tcnt  <= SETTLE_LD;
          end
        end
        S_RESET: begin
          if (tcnt != '0) begin
            tcnt <= tcnt - 1'b1;
          end else begin
            state          <= S_RECOVER;
            ctrl_sel_rst_n <= 1'b1;
            tcnt           <= RST_LD;
          end
        end
        S_RECOVER: begin
          if (tcnt != '0) begin
            tcnt <= tcnt - 1'b1;
          end else if (pulses != '0) begin
            state        <= S_INC_HI;
            ctrl_sel_inc <= 1'b1;
            cur_addr     <= cur_addr + 1'b1;
            pulses       <= pulses - 1'b1;
            tcnt         <= PULSE_LD;
          end else begin
            state <= S_SETTLE;
            tcnt  <= SETTLE_LD;
          end
        end
        S_INC_HI: begin
          if (tcnt != '0) begin
            tcnt <= tcnt - 1'b1;
          end else begin
            state        <= S_INC_LO;
            ctrl_sel_inc <= 1'b0;
            tcnt         <= PULSE_LD;
          end
        end
        S_INC_LO: begin
          if (tcnt != '0) begin
            tcnt <= tcnt - 1'b1;
          end else if (pulses != '0) begin
            state        <= S_INC_HI;
            ctrl_sel_inc <= 1'b1;
            cur_addr     <= cur_addr + 1'b1;
            pulses       <= pulses - 1'b1;
            tcnt         <= PULSE_LD;
          end else begin
            state <= S_SETTLE;
            tcnt  <= SETTLE_LD;
          end
        end
        S_SETTLE: begin
          if (tcnt != '0) begin
            tcnt <= tcnt - 1'b1;
          end else begin
            state     <= S_IDLE;
            ctrl_ena  <= ena_q;
            done      <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Directed bench for tt_ctrl_seq: latency, pulse/reset counts, shadow vs. a ripple-counter
// model, async reset mid-sequence, and busy-time request handling.
module tb_tt_ctrl_seq;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_ena = 1'b0;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] cur_addr;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  tt_ctrl_seq dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_ena        (req_ena),
    .done           (done),
    .busy           (busy),
    .cur_addr       (cur_addr),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference ripple counter as the controller would see it.
  logic [ADDR_W-1:0] model_cnt = '0;
  int inc_edges = 0;
  int rst_lows  = 0;
  always @(posedge ctrl_sel_inc or negedge ctrl_sel_rst_n) begin
    if (!ctrl_sel_rst_n) model_cnt <= '0;
    else                 model_cnt <= model_cnt + 1'b1;
  end
  always @(posedge ctrl_sel_inc)   inc_edges++;
  always @(negedge ctrl_sel_rst_n) rst_lows++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Enable must be low whenever the select lines move; inc never high during counter reset.
  logic prev_inc = 1'b0;
  logic prev_rstn = 1'b0;
  always @(negedge clk) begin
    if (ctrl_sel_inc !== prev_inc || ctrl_sel_rst_n !== prev_rstn) begin
      chk("ena_low_on_toggle", {31'd0, ctrl_ena}, 32'd0);
      chk("no_inc_in_reset", {31'd0, ctrl_sel_inc & ~ctrl_sel_rst_n}, 32'd0);
    end
    prev_inc  = ctrl_sel_inc;
    prev_rstn = ctrl_sel_rst_n;
  end

  task automatic run_req(input int addr, input logic ena, input int lat,
                         input int incs, input int rsts);
    int s_inc, s_rst, k;
    @(negedge clk);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = ADDR_W'(addr);
    req_ena   = ena;
    s_inc = inc_edges;
    s_rst = rst_lows;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = ~req_addr;
    req_ena   = ~ena;
    chk("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
    chk("ena_low_after_accept", {31'd0, ctrl_ena}, 32'd0);
    k = 0;
    for (int i = 1; i <= 5000; i++) begin
      @(posedge clk); #1;
      if (done) begin
        k = i;
        break;
      end
    end
    chk("done_latency", k, lat);
    chk("ctrl_ena_final", {31'd0, ctrl_ena}, {31'd0, ena});
    chk("cur_addr_final", {22'd0, cur_addr}, addr);
    chk("model_cnt_final", {22'd0, model_cnt}, addr);
    chk("inc_edges", inc_edges - s_inc, incs);
    chk("rst_low_pulses", rst_lows - s_rst, rsts);
    chk("ready_at_done", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int k, s_inc;
    // Reset state
    #12;
    chk("rst_rst_n", {31'd0, ctrl_sel_rst_n}, 32'd0);
    chk("rst_inc", {31'd0, ctrl_sel_inc}, 32'd0);
    chk("rst_ena", {31'd0, ctrl_ena}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cur", {22'd0, cur_addr}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_rst_n", {31'd0, ctrl_sel_rst_n}, 32'd1);
    chk("rel_ready", {31'd0, req_ready}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd0);

    // First request after reset: full path, 4+4+3*4+4
    run_req(3, 1'b1, 24, 3, 1);
    // Incremental 3 -> 5
    run_req(5, 1'b1, 16, 2, 0);
    // Backwards: full path 4+4+2*4+4
    run_req(2, 1'b1, 20, 2, 1);
    // Same address, disable: no reset, no pulses
    run_req(2, 1'b0, 8, 0, 0);

    // req_valid held during busy: 2 -> 4 (16 cycles), then 4 -> 7 accepted right after done
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 10'd4;
    req_ena   = 1'b1;
    @(posedge clk); #1;
    req_addr = 10'd7;
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      if (req_ready) chk("ready_while_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      if (done) begin
        k = i;
        break;
      end
    end
    chk("held_first_latency", k, 16);
    chk("held_first_cur", {22'd0, cur_addr}, 32'd4);
    s_inc = inc_edges;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("held_second_accept", {31'd0, busy}, 32'd1);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        k = i;
        break;
      end
    end
    chk("held_second_latency", k, 20);
    chk("held_second_cur", {22'd0, cur_addr}, 32'd7);
    chk("held_second_incs", inc_edges - s_inc, 32'd3);
    @(posedge clk); #1;
    chk("held_no_third", {31'd0, busy}, 32'd0);

    // Async reset during INC_HI of a max-address request
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 10'd1023;
    req_ena   = 1'b1;
    s_inc = inc_edges;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (state_dbg == 3'd4 && inc_edges - s_inc >= 3) begin
        k = i;
        break;
      end
    end
    chk("reached_inc_hi", {31'd0, k != 0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rst_n", {31'd0, ctrl_sel_rst_n}, 32'd0);
    chk("midrst_inc", {31'd0, ctrl_sel_inc}, 32'd0);
    chk("midrst_ena", {31'd0, ctrl_ena}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_cur", {22'd0, cur_addr}, 32'd0);
    chk("midrst_model", {22'd0, model_cnt}, 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cur", {22'd0, cur_addr}, 32'd0);
    chk("post_rst_model", {22'd0, model_cnt}, 32'd0);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    // Max address after reset: full path, 4+4+1023*4+4
    run_req(1023, 1'b1, 4104, 1023, 1);
    // Back to 0: full path with no pulses
    run_req(0, 1'b1, 12, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
